booth_multiplier_32bit: RTL and testbench
=========================================

Name: booth_multiplier_32bit

Overview:
Sequential radix-4 modified-Booth signed multiplier. It produces the full double-width product that the 64-bit product register captures.
- data_result drives that register's in_data.
- data_resultRDY drives that register's input_enable.
- Sits inside the multdiv unit of the pipelined processor, between the execute-stage operand latches and the product register.

Parameters:
WIDTH, 32, operand width; must be even; product is 2*WIDTH bits.
STEPS, WIDTH/2, Booth iterations per operation (localparam, not overridable).

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
ctrl_mult  input  1  start strobe, sampled each rising edge.
data_operandA  input  WIDTH  multiplicand, signed two's complement; sampled only on the edge where ctrl_mult is high.
data_operandB  input  WIDTH  multiplier, signed two's complement; sampled only on the edge where ctrl_mult is high.
data_result  output  2*WIDTH  signed product.
data_resultRDY  output  1  one-cycle pulse; product valid this cycle.
data_exception  output  1  product does not fit in WIDTH signed bits; valid with data_resultRDY.

Behaviour:
- Reset values: state=IDLE, data_result=0, data_resultRDY=0, data_exception=0, iteration counter=0. Reset wins over ctrl_mult on the same edge.
- Datapath registers:
  - mcand: 2*WIDTH, sign-extended A, shifted left 2 per step.
  - mplier: WIDTH+1, B with an appended 0 lookbehind bit, arithmetic-shifted right 2 per step.
  - acc: 2*WIDTH, cleared on start.
  - cnt: log2(STEPS)+1 bits.
- Booth digit = mplier[2:0]:
  - 000 or 111 -> 0
  - 001 or 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101 or 110 -> -M
  - M is mcand. Negation is two's complement at 2*WIDTH bits. All arithmetic is modulo 2^(2*WIDTH).
- FSM:
  - IDLE: if ctrl_mult, load operands, clear acc and cnt -> RUN.
  - RUN: each edge, acc += digit*mcand; shift mcand and mplier; cnt++. When cnt reaches STEPS-1 on this edge -> DONE.
  - DONE: data_resultRDY=1 for this single cycle -> IDLE.
- Outputs are registered:
  - data_result updates from acc on entry to DONE.
  - data_result holds its value until the next DONE or reset. It does not change while the next operation runs.
  - data_exception = NOT(acc[2*WIDTH-1:WIDTH-1] all-0 or all-1). It is captured with data_result and held likewise.
- Latency: ctrl_mult sampled at edge E0. RUN occupies STEPS edges. data_resultRDY is high during the cycle after edge E0+STEPS+1, i.e. 18 cycles for WIDTH=32.
- Start-strobe rules:
  - ctrl_mult high in RUN or DONE aborts the current operation and restarts with the new operands (same as an IDLE start). No data_resultRDY is issued for the aborted operation.
  - ctrl_mult held high for several cycles restarts on every edge. Only the last start completes.
- Reset mid-RUN returns to IDLE, clears the outputs, and issues no data_resultRDY.
- Edge cases:
  - Most negative values (0x80000000) need no special case; the sign-extended 2*WIDTH datapath handles them.
  - Zero operands give a 0 result with exception 0.

Optional Feature:
MULT_EARLY_EXIT_EN.
- Defined: in RUN, after each update, if the post-shift mplier is all-0 or all-1, every remaining digit is 0, so go to DONE immediately.
  - Latency becomes variable: minimum 1 RUN edge (B=0 or B=-1), maximum STEPS.
  - Result and exception are identical to the non-early-exit case.
  - Abort and reset rules are unchanged.
- Undefined: exactly STEPS RUN edges always; fixed latency.

Decomposition:
- Package multdiv_pkg:
  - state enum {IDLE, RUN, DONE}.
  - WIDTH default constant.
  - Booth digit encoding type {ZERO, POS1, POS2, NEG1, NEG2}.
- Sub-module booth_digit_encoder (purely combinational): 3-bit window in -> digit code out. It is shared with the future radix-4 divider quotient logic.
- Counter, FSM and datapath stay in the top module.

Test Plan:
- Basic positive: reset 2 cycles; A=3, B=5, ctrl_mult 1 cycle -> resultRDY pulses exactly once, 18 cycles later; result=0x0000_0000_0000_000F; exception=0.
- Mixed signs: A=-7, B=6 -> result=0xFFFF_FFFF_FFFF_FFD6, exception=0. Then A=0x7FFFFFFF, B=0xFFFFFFFF -> result=0xFFFF_FFFF_8000_0001, exception=0.
- Overflow: A=B=0x80000000 -> result=0x4000_0000_0000_0000, exception=1. A=0x00010000, B=0x00010000 -> result=0x1_0000_0000, exception=1.
- Abort: start A=3, B=5; pulse ctrl_mult again 5 cycles later with A=2, B=4 -> single resultRDY, 18 cycles after the second strobe, result=8. data_result holds its prior value throughout.
- Reset mid-op: start, assert reset in RUN cycle 8 -> outputs 0, no resultRDY within 40 cycles. Next start A=-1, B=-1 -> result=1.
- MULT_EARLY_EXIT_EN build: B=0 -> resultRDY 3 cycles after strobe, result=0. B=1 (A=9) -> result=9 in under 18 cycles. Without the macro, both take 18 cycles.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv unit (multiplier now, divider later).
package multdiv_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    // Radix-4 Booth digit: selects 0, +/-M or +/-2M.
    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

endpackage

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth recoder: 3-bit multiplier window -> signed digit code.
// Purely combinational; also meant for the radix-4 divider quotient logic.
module booth_digit_encoder
    import multdiv_pkg::*;
(
    input  logic [2:0]   window,
    output booth_digit_t digit
);

    // Map the overlapping bit triplet {b[i+1], b[i], b[i-1]} to its digit.
    always_comb begin
        digit = ZERO;
        case (window)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_multiplier_32bit.sv
// Sequential radix-4 Booth signed multiplier, full 2*WIDTH product.
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all-0 or all-1 (every remaining digit is zero).
module booth_multiplier_32bit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_mult,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    output logic [2*WIDTH-1:0] data_result,
    output logic               data_resultRDY,
    output logic               data_exception
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS) + 1;

    mult_state_t        state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH:0]     mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    booth_digit_t       digit;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     mplier_nxt;
    logic               last_step;
    logic [WIDTH:0]     upper_acc;

    booth_digit_encoder u_enc (
        .window (mplier[2:0]),
        .digit  (digit)
    );

    // Partial product for the current digit; negation wraps at 2*WIDTH bits.
    always_comb begin
        addend = '0;
        case (digit)
            ZERO:    addend = '0;
            POS1:    addend = mcand;
            POS2:    addend = mcand << 1;
            NEG1:    addend = -mcand;
            NEG2:    addend = -(mcand << 1);
            default: addend = '0;
        endcase
    end

    // Next-step datapath values and the RUN exit condition.
    always_comb begin
        acc_nxt    = acc + addend;
        mplier_nxt = {{2{mplier[WIDTH]}}, mplier[WIDTH:2]};
        last_step  = (cnt == CW'(STEPS - 1));
`ifdef MULT_EARLY_EXIT_EN
        last_step  = last_step | (&mplier_nxt) | ~(|mplier_nxt);
`endif
    end

    // Bits that must all match the sign for the product to fit in WIDTH bits.
    assign upper_acc = acc[2*WIDTH-1:WIDTH-1];

    // Control FSM, datapath and registered outputs; a start strobe restarts from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            cnt            <= '0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_mult) begin
                state  <= RUN;
                mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                mplier <= {data_operandB, 1'b0};
                acc    <= '0;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    RUN: begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 2;
                        mplier <= mplier_nxt;
                        cnt    <= cnt + 1'b1;
                        if (last_step)
                            state <= DONE;
                    end
                    DONE: begin
                        data_result    <= acc;
                        data_exception <= ~((&upper_acc) | ~(|upper_acc));
                        data_resultRDY <= 1'b1;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier_32bit.sv
// Directed-vector bench for booth_multiplier_32bit.
module tb_booth_multiplier_32bit;

    localparam int LAT = 18;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [63:0] data_result;
    logic        data_resultRDY;
    logic        data_exception;

    int n_checks = 0;
    int n_fail   = 0;

    booth_multiplier_32bit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Strobe ctrl_mult for one edge; returns at the negedge after that edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_mult     = 1'b1;
        @(negedge clock);
        ctrl_mult     = 1'b0;
    endtask

    // Wait for RDY; lat counts the strobe edge as 1. Flags any result change before RDY.
    task automatic wait_rdy(input int budget, output int lat, output bit seen, output bit held);
        logic [63:0] prev;
        prev = data_result;
        seen = 1'b0;
        held = 1'b1;
        lat  = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                seen = 1'b1;
                lat  = i + 1;
                break;
            end
            if (data_result !== prev) held = 1'b0;
        end
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input logic exp_exc);
        int lat;
        bit seen, held;
        start(a, b);
        wait_rdy(40, lat, seen, held);
        chk({tag, "_rdy"}, 64'(seen), 64'd1);
        chk({tag, "_res"}, data_result, exp);
        chk({tag, "_exc"}, 64'(data_exception), 64'(exp_exc));
`ifndef MULT_EARLY_EXIT_EN
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
`endif
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, 64'(data_resultRDY), 64'd0);
    endtask

    initial begin
        int  lat;
        bit  seen, held;
        bit  rdy_seen;

        reset         = 1'b1;
        ctrl_mult     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_res", data_result, 64'd0);
        chk("rst_rdy", 64'(data_resultRDY), 64'd0);
        chk("rst_exc", 64'(data_exception), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        do_mult("pos",   32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0);
        do_mult("mix",   -32'sd7,        32'd6,          64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        do_mult("maxm1", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_8000_0001, 1'b0);
        do_mult("minsq", 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b1);
        do_mult("ovf",   32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 1'b1);
        do_mult("zero",  32'h1234_5678,  32'd0,          64'd0,                   1'b0);

        // Abort: restart 5 cycles after the first strobe; only the second completes.
        start(32'd3, 32'd5);
        rdy_seen = 1'b0;
        held     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen = 1'b1;
            if (data_result !== 64'd0) held = 1'b0;
        end
        start(32'd2, 32'd4);
        if (data_result !== 64'd0) held = 1'b0;
        wait_rdy(40, lat, seen, rdy_seen);
        chk("abort_hold", 64'(held & rdy_seen), 64'd1);
        chk("abort_rdy", 64'(seen), 64'd1);
        chk("abort_res", data_result, 64'd8);
`ifndef MULT_EARLY_EXIT_EN
        chk("abort_lat", 64'(lat), 64'(LAT));
`endif
        @(posedge clock);
        #1;
        chk("abort_single", 64'(data_resultRDY), 64'd0);

        // Reset in the middle of RUN: outputs clear, no RDY follows.
        do_mult("pre_rst", 32'd100, 32'd7, 64'd700, 1'b0);
        start(32'd1234, 32'd5678);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_res", data_result, 64'd0);
        chk("midrst_exc", 64'(data_exception), 64'd0);
        rdy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen = 1'b1;
        end
        chk("midrst_nordy", 64'(rdy_seen), 64'd0);
        do_mult("negsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);

        // Latency of trivially short multipliers.
        start(32'd77, 32'd0);
        wait_rdy(40, lat, seen, held);
        chk("b0_res", data_result, 64'd0);
`ifdef MULT_EARLY_EXIT_EN
        chk("b0_lat", 64'(lat), 64'd3);
`else
        chk("b0_lat", 64'(lat), 64'(LAT));
`endif
        start(32'd9, 32'd1);
        wait_rdy(40, lat, seen, held);
        chk("b1_res", data_result, 64'd9);
`ifdef MULT_EARLY_EXIT_EN
        chk("b1_fast", 64'(lat < LAT), 64'd1);
`else
        chk("b1_lat", 64'(lat), 64'(LAT));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
